// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with glitch-free divisor updates.
// Divisor changes and stops take effect only at period boundaries.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] pend_val, pend_n;
  logic             pend_vld, pend_vld_n;
  logic             clk_n, rise_n, fall_n;
  logic             ack_n, err_n;

  logic             load_ok, load_bad;
  logic [WIDTH-1:0] half, div_eff;
  logic [WIDTH:0]   cnt_inc;
  logic             at_end;

  assign load_ok  = div_load && (div_in >= DIV_MIN);
  assign load_bad = div_load && (div_in < DIV_MIN);
  assign half     = div_cur >> 1;
  assign div_eff  = pend_vld ? pend_val : div_cur;
  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  assign at_end   = (cnt == div_cur - 1'b1);
  assign running  = (state == RUN);

  // Registers: state, counter, divisor bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= DIV_RST;
      pend_val <= '0;
      pend_vld <= 1'b0;
      clk_out  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_cur  <= div_n;
      pend_val <= pend_n;
      pend_vld <= pend_vld_n;
      clk_out  <= clk_n;
      rise_stb <= rise_n;
      fall_stb <= fall_n;
      div_ack  <= ack_n;
      div_err  <= err_n;
    end
  end

  // Next state: period counting, boundary handling and divisor loading.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_n      = div_cur;
    pend_n     = pend_val;
    pend_vld_n = pend_vld;
    clk_n      = clk_out;
    rise_n     = 1'b0;
    fall_n     = 1'b0;
    ack_n      = load_ok;
    err_n      = load_bad;

    case (state)
      IDLE: begin
        cnt_n      = '0;
        clk_n      = 1'b0;
        div_n      = div_eff;
        pend_vld_n = 1'b0;
        if (enable) begin
          state_n = RUN;
          clk_n   = 1'b1;
          rise_n  = 1'b1;
        end
      end
      RUN: begin
        if (at_end) begin
          div_n      = div_eff;
          pend_vld_n = 1'b0;
          cnt_n      = '0;
          if (enable) begin
            clk_n  = 1'b1;
            rise_n = 1'b1;
          end else begin
            state_n = IDLE;
            clk_n   = 1'b0;
          end
        end else begin
          cnt_n  = cnt_inc[WIDTH-1:0];
          clk_n  = (cnt_inc < {1'b0, half});
          fall_n = (cnt_inc == {1'b0, half});
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        clk_n   = 1'b0;
      end
    endcase

    // A load seen while idle and staying idle takes effect at once;
    // otherwise it waits for the next boundary.
    if (load_ok) begin
      if (state == IDLE && !enable) begin
        div_n      = div_in;
        pend_vld_n = 1'b0;
      end else begin
        pend_n     = div_in;
        pend_vld_n = 1'b1;
      end
    end
  end

endmodule
